// File: rtl/fifo_wptr_gray_pkg.sv
// cbb_fifo_pkg: shared async-FIFO helpers (Gray encode, depth, full compare)
package cbb_fifo_pkg;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction
  function automatic logic full_match(input logic [31:0] wg, input logic [31:0] rg, input int unsigned w);
    return wg == (rg ^ (32'd3 << (w - 2)));
  endfunction
endpackage

// File: rtl/fifo_wptr_gray_gray2bin.sv
// gray2bin: combinational Gray to binary decode
module gray2bin #(
  parameter int SIZE = 5
) (
  input  logic [SIZE-1:0] gray,
  output logic [SIZE-1:0] bin
);
  for (genvar i = 0; i < SIZE; i++) begin : g_bit
    assign bin[i] = ^gray[SIZE-1:i];
  end
endmodule

// File: rtl/fifo_wptr_gray.sv
// fifo_wptr_gray: write-side pointer engine with Gray publish, read-pointer sync, full/level flags
module fifo_wptr_gray
  import cbb_fifo_pkg::*;
#(
  parameter int AW          = 4,
  parameter int AFULL_TH    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW:0]   rd_gptr_in,
  output logic          wr_fire,
  output logic [AW-1:0] waddr,
  output logic [AW:0]   wgptr,
  output logic          full,
  output logic          almost_full,
  output logic [AW:0]   wcount
);
  localparam int DEPTH = int'(depth_of(AW));
  localparam int PW    = AW + 1;
  logic [AW:0] wbin, wbin_nxt, wg_nxt, rq, rbin, wcount_nxt;
  logic [AW:0] sync_q [SYNC_STAGES];
  assign wr_fire    = wr_en & ~full & ~rst;
  assign wbin_nxt   = wbin + {{AW{1'b0}}, wr_fire};
  assign wg_nxt     = PW'(bin2gray(32'(wbin_nxt)));
  assign rq         = sync_q[SYNC_STAGES-1];
  assign wcount_nxt = wbin_nxt - rbin;
  assign waddr      = wbin[AW-1:0];
  gray2bin #(.SIZE(PW)) u_g2b (.gray(rq), .bin(rbin));
  always_ff @(posedge clk) begin
    if (rst) begin
      wbin        <= '0;
      wgptr       <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wcount      <= '0;
      sync_q      <= '{default: '0};
    end else begin
      sync_q[0] <= rd_gptr_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      wbin        <= wbin_nxt;
      wgptr       <= wg_nxt;
      full        <= full_match(32'(wg_nxt), 32'(rq), PW);
      almost_full <= 32'(wcount_nxt) >= 32'(DEPTH - AFULL_TH);
      wcount      <= wcount_nxt;
    end
  end
endmodule

// File: tb/tb_fifo_wptr_gray.sv
// tb_fifo_wptr_gray: directed stimulus with a queued scoreboard checked by a negedge monitor
module tb_fifo_wptr_gray;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [4:0] rd_gptr_in = '0;
  logic       wr_fire, full, almost_full;
  logic [3:0] waddr;
  logic [4:0] wgptr, wcount;
  fifo_wptr_gray #(.AW(4), .AFULL_TH(2), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_gptr_in(rd_gptr_in),
    .wr_fire(wr_fire), .waddr(waddr), .wgptr(wgptr), .full(full),
    .almost_full(almost_full), .wcount(wcount)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {int cyc; int sel; int val;} exp_t;
  exp_t q[$];
  exp_t e;
  int n_cmp = 0, n_bad = 0;
  bit ham_on = 1'b0;
  logic [4:0] prev_g = '0;
  string nm [6] = '{"wgptr", "waddr", "wcount", "full", "almost_full", "wr_fire"};
  int gtab [17] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 24};
  function automatic int act(int s);
    case (s)
      0: return int'(wgptr);
      1: return int'(waddr);
      2: return int'(wcount);
      3: return int'(full);
      4: return int'(almost_full);
      default: return int'(wr_fire);
    endcase
  endfunction
  function automatic int g(int x);
    int y = x & 31;
    return y ^ (y >> 1);
  endfunction
  task automatic ex(input int s, input int v);
    q.push_back('{cyc, s, v});
  endtask
  task automatic step(input logic w, input logic [4:0] r, input logic rs = 1'b0);
    @(posedge clk);
    #1;
    rst = rs;
    wr_en = w;
    rd_gptr_in = r;
  endtask
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_cmp++;
      if (e.cyc < cyc || act(e.sel) != e.val) begin
        n_bad++;
        $display("FAIL %s at cycle %0d: got %0d expected %0d", nm[e.sel], e.cyc, act(e.sel), e.val);
      end
    end
    if (ham_on) begin
      n_cmp++;
      if ($countones(wgptr ^ prev_g) > 1) begin
        n_bad++;
        $display("FAIL hamming at cycle %0d: got %b after %b, required distance <= 1", cyc, wgptr, prev_g);
      end
    end
    prev_g = wgptr;
  end
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete, required finish before 20000");
    $fatal(1);
  end
  initial begin
    repeat (3) step(1'b1, 5'd0, 1'b1);
    for (int s = 0; s < 6; s++) ex(s, 0);
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 5'd0);
      ex(0, gtab[i <= 16 ? i - 1 : 16]);
      ex(1, (i <= 17 ? i - 1 : 16) % 16);
      ex(2, i <= 17 ? i - 1 : 16);
      ex(3, int'(i >= 17));
      ex(4, int'(i >= 15));
      ex(5, int'(i <= 16));
    end
    step(1'b0, 5'b00110);
    ex(3, 1); ex(2, 16);
    step(1'b0, 5'b00110);
    step(1'b0, 5'b00110);
    ex(3, 1); ex(2, 16);
    step(1'b0, 5'b00110);
    ex(3, 0); ex(2, 12); ex(4, 0);
    ham_on = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      step(1'b1, 5'(g(4 + j)));
      ex(0, g(16 + j - 1));
      ex(5, 1);
      ex(3, 0);
      if (j >= 4) ex(2, 14);
      if (j == 16) ex(0, 5'b10000);
      if (j == 17) ex(0, 5'b00000);
    end
    ham_on = 1'b0;
    for (int d = 1; d <= 4; d++) begin
      step(1'b0, 5'(g(28)));
      ex(5, 0);
      if (d == 4) ex(2, 8);
    end
    for (int k = 1; k <= 12; k++) begin
      step(k >= 3, 5'(g(28 + k)));
      ex(2, 8);
      ex(3, 0);
      ex(5, int'(k >= 3));
    end
    for (int h = 1; h <= 5; h++) begin
      step(1'b1, 5'(g(8)), h == 5);
      if (h == 4) ex(2, 9);
      if (h == 5) ex(2, 10);
    end
    step(1'b0, 5'(g(8)));
    for (int s = 0; s < 6; s++) ex(s, 0);
    repeat (2) @(posedge clk);
    #1;
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d unchecked entries, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
